// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit_pkg
//  Description : Shared definitions for the iterative divider. Holds the
//                default datapath width, the divide-operation encoding and
//                the divider FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    localparam int c_xlen_default = 32;

    // Encoding matches the 2-bit op field from decode: bit 1 selects the
    // remainder, bit 0 selects unsigned operation.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle restoring divider for the Execute stage.
//                Handles DIV/DIVU/REM/REMU, including divide-by-zero and
//                signed overflow, which complete without iterating.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                start          - divide op valid in Execute
//                flushE         - Execute flush; kills any in-flight op
//                op, a, b       - operation, dividend, divisor
//                stall_req      - hold F/D/E while the divide is busy
//                done, result   - one-cycle result strobe and value
//  Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = c_xlen_default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flushE,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              c_cnt_w   = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e         r_state;
    div_state_e         w_state_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [XLEN-1:0]    r_quot;      // dividend shifts out as quotient shifts in
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_divisor;
    logic               r_is_rem;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_signed;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [XLEN-1:0]    w_abs_a;
    logic [XLEN-1:0]    w_abs_b;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_special;
    logic               w_accept;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_trial;
    logic               w_fits;
    logic [XLEN-1:0]    w_q_fixed;
    logic [XLEN-1:0]    w_r_fixed;

    // ---------------------------------------------------------------- decode
    assign w_signed   = ~op[0];
    assign w_sign_a   = w_signed & a[XLEN-1];
    assign w_sign_b   = w_signed & b[XLEN-1];
    assign w_abs_a    = w_sign_a ? (~a + 1'b1) : a;
    assign w_abs_b    = w_sign_b ? (~b + 1'b1) : b;
    assign w_div_zero = (b == '0);
    assign w_ovf      = w_signed & (a == c_int_min) & (b == '1);
    assign w_special  = w_div_zero | w_ovf;
    assign w_accept   = (r_state == ST_IDLE) & start & ~flushE;

    // ------------------------------------------------- restoring divide step
    // The partial remainder is always below the divisor, so the shifted value
    // fits in XLEN+1 bits and the top bit of the trial difference is the borrow.
    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_divisor};
    assign w_fits  = ~w_trial[XLEN];

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_count == '0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (flushE) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_is_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (w_accept) begin
            r_is_rem  <= op[1];
            r_divisor <= w_abs_b;
            if (w_special) begin
                // Final values are loaded directly; no sign fix applies.
                r_count <= '0;
                r_quot  <= w_div_zero ? '1 : c_int_min;
                r_rem   <= w_div_zero ? a : '0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else begin
                r_count <= c_cnt_w'(XLEN - 1);
                r_quot  <= w_abs_a;
                r_rem   <= '0;
                r_neg_q <= w_sign_a ^ w_sign_b;
                r_neg_r <= w_sign_a;
            end
        end else if ((r_state == ST_CALC) && !flushE) begin
            r_count <= r_count - 1'b1;
            r_quot  <= {r_quot[XLEN-2:0], w_fits};
            r_rem   <= w_fits ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
        end
    end

    // ---------------------------------------------------------------- outputs
    assign w_q_fixed = r_neg_q ? (~r_quot + 1'b1) : r_quot;
    assign w_r_fixed = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    // Reset and flush mask the outputs in the same cycle they are asserted.
    assign stall_req = ~rst & ~flushE &
                       (((r_state == ST_IDLE) & start) | (r_state == ST_CALC));
    assign done      = ~rst & ~flushE & (r_state == ST_DONE);
    assign result    = done ? (r_is_rem ? w_r_fixed : w_q_fixed) : '0;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit (XLEN=32). A scoreboard
//                queue holds expected result and completion cycle per op;
//                a monitor pops it on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam int XLEN = 32;

    typedef struct {
        logic [XLEN-1:0] res;
        int              cyc;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            start;
    logic            flushE;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            stall_req;
    logic            done;
    logic [XLEN-1:0] result;

    int   cyc;
    int   checks;
    int   failures;
    exp_t sbq[$];

    div_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flushE    (flushE),
        .op        (op),
        .a         (a),
        .b         (b),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model written from the ISA semantics, independent of the RTL.
    function automatic logic [XLEN-1:0] model(input logic [1:0] o,
                                              input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
        logic signed [XLEN-1:0] sx;
        logic signed [XLEN-1:0] sy;
        sx = $signed(x);
        sy = $signed(y);
        if (y == '0) return o[1] ? x : '1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : 32'h8000_0000;
        if (o[0]) return o[1] ? (x % y) : (x / y);
        return o[1] ? $unsigned(sx % sy) : $unsigned(sx / sy);
    endfunction

    // Monitor: every done pulse must match the next scoreboard entry, and
    // result must be zero whenever done is low.
    always @(negedge clk) begin
        checks++;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done cycle=%0d result=%h", cyc, result);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (result !== e.res || cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL done_result got=%h@%0d expected=%h@%0d",
                             result, cyc, e.res, e.cyc);
                end
            end
        end else if (done !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL idle_outputs done=%b result=%h expected done=0 result=0",
                     done, result);
        end
    end

    // Issue one op, check stall_req every cycle up to completion, and confirm
    // the scoreboard entry was consumed by the monitor.
    task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] x,
                          input logic [XLEN-1:0] y, input logic [XLEN-1:0] exp_res,
                          input int lat);
        int k;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        k = cyc;
        sbq.push_back('{exp_res, k + lat});
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            checks++;
            if (stall_req !== (i < lat)) begin
                failures++;
                $display("FAIL stall_req op=%0d cycle=%0d got=%b expected=%b",
                         o, i, stall_req, (i < lat));
            end
            if (i == 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL no_done op=%0d a=%h b=%h pending=%0d expected=0",
                     o, x, y, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; flushE = 1'b0; op = 2'b00;
        a = 32'd100; b = 32'd3;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (stall_req !== 1'b0 || done !== 1'b0 || result !== '0) begin
                failures++;
                $display("FAIL reset_outputs stall=%b done=%b result=%h expected 0/0/0",
                         stall_req, done, result);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_req !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL post_reset stall=%b done=%b expected 0/0", stall_req, done);
        end
    endtask

    task automatic test_directed();
        run_op(2'b00, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFA, 33);
        run_op(2'b10, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFE, 33);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h10,         32'h0FFF_FFFF, 33);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h10,         32'h0000_000F, 33);
        run_op(2'b00, 32'd7,         32'd0,          32'hFFFF_FFFF, 1);
        run_op(2'b10, 32'd7,         32'd0,          32'd7,         1);
        run_op(2'b01, 32'hDEAD_BEEF, 32'd0,          32'hFFFF_FFFF, 1);
        run_op(2'b11, 32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 1);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         1);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         33);
        run_op(2'b10, 32'd20,        32'hFFFF_FFFD,  32'd2,         33);
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [1:0]      o;
            logic [XLEN-1:0] x;
            logic [XLEN-1:0] y;
            int              lat;
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 4))
                0:       y = 32'd0;
                1, 2:    y = 32'($signed(12'($urandom)));
                default: y = $urandom;
            endcase
            lat = (y == 0 || (!o[0] && x == 32'h8000_0000 && y == '1)) ? 1 : 33;
            run_op(o, x, y, model(o, x, y), lat);
        end
    endtask

    task automatic test_flush();
        int k;
        // Flush in the same cycle as start: op must not be accepted.
        @(posedge clk); #1;
        start = 1'b1; flushE = 1'b1; op = 2'b00; a = 32'd9; b = 32'd3;
        @(negedge clk);
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_beats_start stall=%b expected=0", stall_req);
        end
        @(posedge clk); #1;
        start = 1'b0; flushE = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_accept stall=%b expected=0", stall_req);
        end
        // Flush in CALC cycle 10.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd7;
        k = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flushE = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_req !== 1'b0 || done !== 1'b0 || cyc !== k + 10) begin
            failures++;
            $display("FAIL flush_calc stall=%b done=%b cycle=%0d expected 0/0/%0d",
                     stall_req, done, cyc - k, 10);
        end
        @(posedge clk); #1;
        flushE = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle stall=%b expected=0", stall_req);
        end
        run_op(2'b00, 32'd100, 32'd7, 32'd14, 33);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; a = 32'd5000; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1; start = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0 || done !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL reset_mid stall=%b done=%b result=%h expected 0/0/0",
                     stall_req, done, result);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (stall_req !== 1'b0) begin
                failures++;
                $display("FAIL reset_abandon stall=%b cycle=%0d expected=0", stall_req, i);
            end
        end
        run_op(2'b11, 32'd5000, 32'd9, 32'd5, 33);
    endtask

    task automatic test_back_to_back();
        int k;
        // start held through CALC and DONE with changing operands.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd7;
        k = cyc;
        sbq.push_back('{32'd142, k + 33});
        @(posedge clk); #1;
        op = 2'b10; a = 32'd5; b = 32'd0;
        repeat (32) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL b2b_hold pending=%0d expected=0", sbq.size());
            sbq.delete();
        end
        // Divide-by-zero ops back to back: accepted in IDLE cycles only.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; a = 32'd7; b = 32'd0;
        k = cyc;
        sbq.push_back('{32'd7, k + 1});
        sbq.push_back('{32'd7, k + 3});
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL b2b_special pending=%0d expected=0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0; checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; flushE = 1'b0; op = 2'b00; a = '0; b = '0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_div_unit
`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  valid divide op present in Execute stage.
REQ-005 SHALL have port flushE  input  1  Execute-stage flush from hazard unit; kills in-flight op.
REQ-006 SHALL have port op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port a  input  XLEN  dividend (forwarded operand A).
REQ-008 SHALL have port b  input  XLEN  divisor (forwarded operand B).
REQ-009 SHALL have port stall_req  output  1  request to hazard unit to stall F/D/E and bubble M.
REQ-010 SHALL have port done  output  1  result valid; one-cycle pulse.
REQ-011 SHALL have port result  output  XLEN  quotient or remainder per latched op.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: start=1 and flushE=0 -> latch op, operand signs, |a|, |b| (unsigned ops: raw values); go CALC, counter=XLEN-1.
REQ-014 IDLE: start=1 with b==0 or signed overflow (DIV/REM, a=-2^(XLEN-1), b=-1) -> skip CALC, go DONE next cycle.
REQ-015 CALC: one restoring-division step per cycle (shift remainder, trial subtract, set quotient bit); counter decrements; counter==0 -> DONE.
REQ-016 DONE: done=1 one cycle, result valid, next state IDLE.
REQ-017 Normal latency: start sampled cycle 0; CALC cycles 1..XLEN; done in cycle XLEN+1 (33 for XLEN=32).
REQ-018 stall_req SHALL be combinational: high when (IDLE and start and not flushE) or state==CALC; low in DONE so the instruction leaves Execute with result.
REQ-019 Sign fix: signed quotient negated iff sign(a)!=sign(b); signed remainder takes sign of a.
REQ-020 Divide by zero: quotient = all ones, remainder = a (unsigned and signed).
REQ-021 Overflow: quotient = -2^(XLEN-1), remainder = 0.
REQ-022 flushE=1 in any state -> IDLE next cycle, no done pulse, stall_req low that cycle; flushE beats start.
REQ-023 start ignored outside IDLE; operands not re-sampled during CALC.
REQ-024 result SHALL be 0 whenever done=0.
REQ-025 start re-asserted in DONE cycle SHALL NOT begin a new op; accepted next IDLE cycle only.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, counter 0, quotient/remainder/latched operands 0.
REQ-027 During and after reset: stall_req=0, done=0, result=0.
REQ-028 Reset mid-CALC SHALL abandon op; no done pulse after release.

Structure
REQ-029 Shared package SHALL hold XLEN default, div op enum (DIV/DIVU/REM/REMU), FSM state enum.
REQ-030 Single module; no sub-module; one registered FSM, one datapath register set, combinational sign fix.

Verification
REQ-031 DIV a=-20, b=3: stall_req high cycles 0..32, done cycle 33, result=-6; REM same operands -> -2.
REQ-032 DIVU a=0xFFFFFFFF, b=0x10 -> 0x0FFFFFFF; REMU -> 0xF; latency 33.
REQ-033 DIV b=0, a=7 -> done cycle 1, result 0xFFFFFFFF; REM -> 7; stall_req high cycle 0 only.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 cycle 1; REM -> 0.
REQ-035 flushE at cycle 10 of CALC -> IDLE cycle 11, no done, stall_req low from cycle 10; new start cycle 12 completes normally.
REQ-036 rst asserted at cycle 5 of CALC -> outputs 0 immediately; no done after release; start ignored while rst high.
